// File: rtl/load_writeback_unit.sv
// Memory-stage load handler: issues one word-aligned read at a time, extends the
// returned data, and arbitrates the register-file write port against ALU results.
module load_writeback_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_funct3,
   input  logic [4:0]  ld_rd,
   input  logic        alu_wb_en,
   input  logic [4:0]  alu_wb_rd,
   input  logic [31:0] alu_wb_data,
   output logic        alu_stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err,
   output logic        write_en_3,
   output logic [4:0]  write_addr_3,
   output logic [31:0] write_data_3,
   output logic        busy_valid,
   output logic [4:0]  busy_rd,
   output logic        load_fault,
   output logic [31:0] fault_addr
);

   typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_reg, state_next;
   logic [31:0] addr_reg;
   logic [2:0]  funct3_reg;
   logic [4:0]  rd_reg;
   logic [31:0] data_reg;
   logic [7:0]  cnt_reg;
   logic        load_fault_reg;
   logic [31:0] fault_addr_reg;

   logic        accept;
   logic        illegal;
   logic        fault_now;
   logic [31:0] fault_addr_next;
   logic [31:0] ext_data;
   logic [7:0]  byte_lane [4];
   logic [15:0] half_lane [2];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   assign accept = ld_valid & (state_reg == IDLE);

   always_comb begin
      illegal = 1'b0;
      case (ld_funct3)
         3'b000, 3'b100: illegal = 1'b0;
         3'b001, 3'b101: illegal = ld_addr[0];
         3'b010:         illegal = (ld_addr[1:0] != 2'b00);
         default:        illegal = 1'b1;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign byte_lane[gi] = mem_rdata[8*gi +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half
         assign half_lane[gi] = mem_rdata[16*gi +: 16];
      end
   endgenerate

   assign sel_byte = byte_lane[addr_reg[1:0]];
   assign sel_half = half_lane[addr_reg[1]];

   always_comb begin
      ext_data = mem_rdata;
      case (funct3_reg)
         3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
         3'b100:  ext_data = {24'd0, sel_byte};
         3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
         3'b101:  ext_data = {16'd0, sel_half};
         default: ext_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_next      = state_reg;
      fault_now       = 1'b0;
      fault_addr_next = addr_reg;
      case (state_reg)
         IDLE: begin
            fault_addr_next = ld_addr;
            if (accept) begin
               if (illegal) fault_now = 1'b1;
               else         state_next = REQ;
            end
         end
         REQ: begin
            // An ack in the final allowed cycle takes precedence over the timeout.
            if (mem_ack) begin
               if (mem_err) begin
                  fault_now  = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = WB;
               end
            end else if (cnt_reg == TIMEOUT_LAST) begin
               fault_now  = 1'b1;
               state_next = IDLE;
            end
         end
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         addr_reg       <= 32'd0;
         funct3_reg     <= 3'd0;
         rd_reg         <= 5'd0;
         data_reg       <= 32'd0;
         cnt_reg        <= 8'd0;
         load_fault_reg <= 1'b0;
         fault_addr_reg <= 32'd0;
      end else begin
         state_reg      <= state_next;
         load_fault_reg <= fault_now;
         if (fault_now) fault_addr_reg <= fault_addr_next;
         if (accept) begin
            addr_reg   <= ld_addr;
            funct3_reg <= ld_funct3;
            rd_reg     <= ld_rd;
         end
         if ((state_reg == REQ) && mem_ack && !mem_err) data_reg <= ext_data;
         if ((state_reg == REQ) && !mem_ack) cnt_reg <= cnt_reg + 8'd1;
         else                                cnt_reg <= 8'd0;
      end
   end

   assign ld_ready   = (state_reg == IDLE);
   assign mem_req    = (state_reg == REQ);
   assign mem_addr   = {addr_reg[31:2], 2'b00};
   assign busy_valid = (state_reg == REQ);
   assign busy_rd    = (state_reg == REQ) ? rd_reg : 5'd0;
   assign load_fault = load_fault_reg;
   assign fault_addr = fault_addr_reg;

   // Reset forces the ALU pass-through even if the state register still reads WB.
   always_comb begin
      alu_stall    = 1'b0;
      write_en_3   = alu_wb_en & (alu_wb_rd != 5'd0);
      write_addr_3 = alu_wb_rd;
      write_data_3 = alu_wb_data;
      if ((state_reg == WB) && rst_n) begin
         alu_stall    = alu_wb_en;
         write_en_3   = (rd_reg != 5'd0);
         write_addr_3 = rd_reg;
         write_data_3 = data_reg;
      end
   end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit: register-file writes are checked against
// a queue of expected {rd,data} pairs; control outputs are checked cycle by cycle.
module tb_load_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_addr;
   logic [2:0]  ld_funct3;
   logic [4:0]  ld_rd;
   logic        alu_wb_en;
   logic [4:0]  alu_wb_rd;
   logic [31:0] alu_wb_data;
   logic        alu_stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_err;
   logic        write_en_3;
   logic [4:0]  write_addr_3;
   logic [31:0] write_data_3;
   logic        busy_valid;
   logic [4:0]  busy_rd;
   logic        load_fault;
   logic [31:0] fault_addr;

   int total = 0;
   int bad   = 0;
   logic [36:0] sb_q [$];

   always #5 clk = ~clk;

   load_writeback_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
      .ld_funct3(ld_funct3), .ld_rd(ld_rd),
      .alu_wb_en(alu_wb_en), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
      .alu_stall(alu_stall),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .mem_err(mem_err),
      .write_en_3(write_en_3), .write_addr_3(write_addr_3), .write_data_3(write_data_3),
      .busy_valid(busy_valid), .busy_rd(busy_rd),
      .load_fault(load_fault), .fault_addr(fault_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and retire any register-file write seen there.
   task automatic step();
      logic [36:0] exp_wr;
      @(negedge clk);
      if (write_en_3 !== 1'b0) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL unexpected_write observed=%0d/%h expected=none",
                   write_addr_3, write_data_3);
         end else begin
            exp_wr = sb_q.pop_front();
            assert ({write_addr_3, write_data_3} === exp_wr) else begin
               bad++;
               $error("FAIL wb_data observed=%0d/%h expected=%0d/%h",
                      write_addr_3, write_data_3, exp_wr[36:32], exp_wr[31:0]);
            end
            $display("write rd=%0d data=%h", write_addr_3, write_data_3);
         end
      end
   endtask

   task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata, input int ack_at,
                          input logic [31:0] exp_data);
      ld_valid = 1'b1; ld_funct3 = f3; ld_addr = addr; ld_rd = rd;
      if (rd != 5'd0) sb_q.push_back({rd, exp_data});
      step();
      ld_valid = 1'b0;
      chk({tag, "_req"}, 32'(mem_req), 32'd1);
      chk({tag, "_maddr"}, mem_addr, {addr[31:2], 2'b00});
      chk({tag, "_busy"}, 32'(busy_valid), 32'd1);
      chk({tag, "_busy_rd"}, 32'(busy_rd), 32'(rd));
      chk({tag, "_ready"}, 32'(ld_ready), 32'd0);
      for (int k = 1; k < ack_at; k++) begin
         step();
         chk({tag, "_req_hold"}, 32'(mem_req), 32'd1);
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      step();
      mem_ack = 1'b0;
      chk({tag, "_wen"}, 32'(write_en_3), 32'(rd != 5'd0));
      if (rd != 5'd0) chk({tag, "_wdata"}, write_data_3, exp_data);
      chk({tag, "_wb_busy"}, 32'(busy_valid), 32'd0);
      chk({tag, "_wb_req"}, 32'(mem_req), 32'd0);
      chk({tag, "_wb_fault"}, 32'(load_fault), 32'd0);
      step();
      chk({tag, "_idle"}, 32'(ld_ready), 32'd1);
      chk({tag, "_nofault"}, 32'(load_fault), 32'd0);
      $display("load %s f3=%0d addr=%h rd=%0d done", tag, f3, addr, rd);
   endtask

   task automatic illegal_op(input string tag, input logic [2:0] f3, input logic [31:0] addr);
      ld_valid = 1'b1; ld_funct3 = f3; ld_addr = addr; ld_rd = 5'd4;
      step();
      ld_valid = 1'b0;
      chk({tag, "_fault"}, 32'(load_fault), 32'd1);
      chk({tag, "_faddr"}, fault_addr, addr);
      chk({tag, "_noreq"}, 32'(mem_req), 32'd0);
      chk({tag, "_ready"}, 32'(ld_ready), 32'd1);
      step();
      chk({tag, "_pulse"}, 32'(load_fault), 32'd0);
      chk({tag, "_noreq2"}, 32'(mem_req), 32'd0);
      $display("illegal %s f3=%0d addr=%h done", tag, f3, addr);
   endtask

   initial begin
      rst_n = 1'b0; ld_valid = 1'b0; ld_addr = 32'd0; ld_funct3 = 3'd0; ld_rd = 5'd0;
      alu_wb_en = 1'b0; alu_wb_rd = 5'd0; alu_wb_data = 32'd0;
      mem_ack = 1'b0; mem_rdata = 32'd0; mem_err = 1'b0;
      step(); step();
      chk("rst_ready", 32'(ld_ready), 32'd1);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_maddr", mem_addr, 32'd0);
      chk("rst_busy", 32'(busy_valid), 32'd0);
      chk("rst_busy_rd", 32'(busy_rd), 32'd0);
      chk("rst_fault", 32'(load_fault), 32'd0);
      chk("rst_faddr", fault_addr, 32'd0);
      // ALU pass-through while reset is held
      alu_wb_en = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h33;
      sb_q.push_back({5'd3, 32'h33});
      step();
      chk("rst_stall", 32'(alu_stall), 32'd0);
      alu_wb_en = 1'b0;
      rst_n = 1'b1;
      step();

      load_op("lw",  3'b010, 32'h100, 5'd5, 32'hDEADBEEF, 1, 32'hDEADBEEF);
      load_op("lb",  3'b000, 32'h103, 5'd1, 32'h80123456, 1, 32'hFFFFFF80);
      load_op("lbu", 3'b100, 32'h103, 5'd2, 32'h80123456, 1, 32'h00000080);
      load_op("lh",  3'b001, 32'h102, 5'd3, 32'h8001ABCD, 2, 32'hFFFF8001);
      load_op("lhu", 3'b101, 32'h100, 5'd4, 32'h8001ABCD, 1, 32'h0000ABCD);
      load_op("lb1", 3'b000, 32'h101, 5'd6, 32'h80123456, 1, 32'h00000034);

      illegal_op("lw_mis", 3'b010, 32'h102);
      illegal_op("f3_011", 3'b011, 32'h200);
      illegal_op("lh_odd", 3'b001, 32'h301);

      // Timeout with no ack: mem_req for exactly 4 cycles, then fault.
      ld_valid = 1'b1; ld_funct3 = 3'b010; ld_addr = 32'h200; ld_rd = 5'd6;
      step();
      ld_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("to_req", 32'(mem_req), 32'd1);
         step();
      end
      chk("to_req_drop", 32'(mem_req), 32'd0);
      chk("to_fault", 32'(load_fault), 32'd1);
      chk("to_faddr", fault_addr, 32'h200);
      step();
      chk("to_pulse", 32'(load_fault), 32'd0);
      $display("timeout no-ack done");

      load_op("ack4", 3'b010, 32'h240, 5'd7, 32'hCAFEF00D, 4, 32'hCAFEF00D);

      // Bus error in the second REQ cycle.
      ld_valid = 1'b1; ld_funct3 = 3'b010; ld_addr = 32'h300; ld_rd = 5'd8;
      step();
      ld_valid = 1'b0;
      step();
      mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 32'h5555AAAA;
      step();
      mem_ack = 1'b0; mem_err = 1'b0;
      chk("err_req", 32'(mem_req), 32'd0);
      chk("err_fault", 32'(load_fault), 32'd1);
      chk("err_faddr", fault_addr, 32'h300);
      chk("err_ready", 32'(ld_ready), 32'd1);
      step();
      $display("bus error done");

      // ALU request colliding with a load writeback.
      ld_valid = 1'b1; ld_funct3 = 3'b010; ld_addr = 32'h400; ld_rd = 5'd9;
      sb_q.push_back({5'd9, 32'h12345678});
      step();
      ld_valid = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      alu_wb_en = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 32'h11;
      sb_q.push_back({5'd7, 32'h11});
      step();
      chk("col_rd", 32'(write_addr_3), 32'd9);
      chk("col_stall", 32'(alu_stall), 32'd1);
      step();
      chk("col_alu_rd", 32'(write_addr_3), 32'd7);
      chk("col_alu_data", write_data_3, 32'h11);
      chk("col_nostall", 32'(alu_stall), 32'd0);
      alu_wb_en = 1'b0;
      step();
      $display("alu collision done");

      load_op("x0", 3'b010, 32'h500, 5'd0, 32'h01020304, 1, 32'h01020304);

      // Reset while a request is outstanding.
      ld_valid = 1'b1; ld_funct3 = 3'b010; ld_addr = 32'h600; ld_rd = 5'd10;
      step();
      ld_valid = 1'b0;
      chk("mr_req", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      step();
      chk("mr_req_drop", 32'(mem_req), 32'd0);
      chk("mr_busy", 32'(busy_valid), 32'd0);
      chk("mr_ready", 32'(ld_ready), 32'd1);
      chk("mr_wen", 32'(write_en_3), 32'd0);
      rst_n = 1'b1;
      step();
      chk("mr_nofault", 32'(load_fault), 32'd0);
      step();
      chk("mr_nowrite", 32'(write_en_3), 32'd0);
      $display("reset mid-op done");

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_writeback_unit.md
# load_writeback_unit

Memory-stage load handler and writeback arbiter for the RISC-V core. It accepts one load at a time from execute, performs a word-aligned data-memory read over a request/acknowledge handshake, and aligns and sign- or zero-extends the returned data. It then drives the register file write port (`write_en_3` / `write_addr_3` / `write_data_3`), merging load results with ALU results. Load writeback has priority over ALU writeback. A busy-destination output lets decode stall on load-use hazards.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum number of `mem_req` cycles before a load faults. Legal range is 1..255 (8-bit counter).

- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ld_valid` in 1: load issue request from execute.
- `ld_ready` out 1: unit can accept a load. High only in IDLE.
- `ld_addr` in 32: byte address of the load.
- `ld_funct3` in 3: load type. 000=LB, 001=LH, 010=LW, 100=LBU, 101=LHU.
- `ld_rd` in 5: load destination register.
- `alu_wb_en` in 1: ALU result writeback request.
- `alu_wb_rd` in 5: ALU result destination register.
- `alu_wb_data` in 32: ALU result.
- `alu_stall` out 1: ALU writeback blocked this cycle. Execute must hold its inputs.
- `mem_req` out 1: data-memory read request.
- `mem_addr` out 32: word-aligned address, `{ld_addr[31:2],2'b00}`.
- `mem_ack` in 1: memory response valid.
- `mem_rdata` in 32: memory read data.
- `mem_err` in 1: bus error. Qualified by `mem_ack`.
- `write_en_3` out 1: register file write enable.
- `write_addr_3` out 5: register file write address.
- `write_data_3` out 32: register file write data.
- `busy_valid` out 1: a load is outstanding.
- `busy_rd` out 5: destination register of the outstanding load.
- `load_fault` out 1: one-cycle fault pulse.
- `fault_addr` out 32: byte address of the most recent faulting load.

## Operation
- **FSM states:** IDLE, REQ, WB.
- **Accept:** a load is accepted when `ld_valid & ld_ready` at a rising edge. On accept, the unit latches addr, funct3 and rd.
- **Illegal loads:** these are detected at accept and cause a fault. The state stays IDLE, no `mem_req` is issued and there is no writeback. A load is illegal if any of the following holds:
  - funct3 is 011, 110 or 111.
  - LH/LHU with `addr[0]=1`.
  - LW with `addr[1:0]!=0`.
- **Legal loads:** go to REQ.
- **REQ state:**
  - `mem_req=1` and `mem_addr` is held stable until `mem_ack`.
  - `mem_ack & ~mem_err`: capture `mem_rdata` and go to WB.
  - `mem_ack & mem_err`: fault, go to IDLE.
  - No ack in the `TIMEOUT_CYCLES`-th REQ cycle: fault, go to IDLE. An ack in that same cycle wins over the timeout.
- **WB state:** one cycle, then IDLE.
  - `write_en_3 = (rd!=0)`, `write_addr_3 = rd`, `write_data_3` = extended data.
- **Alignment** (offset `o = addr[1:0]`):
  - Byte = `rdata[8o+7:8o]`.
  - Half = `rdata[16·addr[1]+15 : 16·addr[1]]`.
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word unchanged.
- **Outside WB:** the write port is a combinational pass-through of `alu_wb_en` (suppressed when `alu_wb_rd==0`), `alu_wb_rd` and `alu_wb_data`.
- **In WB:** `alu_stall = alu_wb_en`. The ALU request is not written that cycle and must be presented again.
- **Busy outputs:** `busy_valid = (state==REQ)`; `busy_rd` = latched rd. The busy outputs are low in WB because the register file forwards same-cycle write data.
- **Fault reporting:** `load_fault` is a registered pulse in the cycle after the fault decision. `fault_addr` updates only on a fault.
- **Reset mid-operation:** returns to IDLE, drops `mem_req`, discards the pending load (no writeback, no fault) and clears the timeout counter.

## Timing
- **Reset values** (registered outputs):
  - `ld_ready=1`, `mem_req=0`, `mem_addr=0`.
  - `busy_valid=0`, `busy_rd=0`.
  - `load_fault=0`, `fault_addr=0`.
- **Write port during reset:** shows the ALU pass-through. `alu_stall=0`.
- **Accept at edge N:**
  - `mem_req` is high from cycle N+1.
  - If `mem_ack` arrives in cycle M ≥ N+1, WB is cycle M+1 and the register is written at the end of M+1.
  - The unit returns to IDLE in cycle M+2.
- **Minimum latency:** accept edge to register update is 2 cycles.
- **Throughput:** at most one load per 3 cycles.
- **Timeout counter:** cleared on entering REQ and incremented each REQ cycle without ack. `mem_req` is high for at most `TIMEOUT_CYCLES` consecutive cycles.
- **Illegal load at edge N:** `load_fault` is high in cycle N+1 and `ld_ready` stays 1.
- **Ack outside REQ:** `mem_ack` is ignored.

## Test plan
- **LW, immediate ack:** LW addr 0x100, rd=5, `mem_rdata`=0xDEADBEEF acked in the first REQ cycle -> `mem_addr`=0x100, then `write_en_3=1`, `write_addr_3=5`, `write_data_3`=0xDEADBEEF exactly 2 cycles after accept; `busy_valid` high 1 cycle.
- **Byte/half extension:**
  - LB addr 0x103 with rdata 0x80123456 -> 0xFFFFFF80.
  - LBU at the same address -> 0x00000080.
  - LH addr 0x102 with rdata 0x8001ABCD -> 0xFFFF8001.
  - LHU addr 0x100 with the same rdata -> 0x0000ABCD.
- **Illegal loads:**
  - LW addr 0x102 -> no `mem_req`, `load_fault` pulse 1 cycle, `fault_addr`=0x102, no write.
  - funct3=011 -> same behaviour.
- **Timeout (`TIMEOUT_CYCLES`=4):**
  - No ack -> `mem_req` high exactly 4 cycles, fault, no write.
  - Ack in the 4th cycle -> normal writeback, no fault.
  - `mem_ack` with `mem_err` in cycle 2 -> fault, IDLE.
- **ALU collision:** `alu_wb_en=1` (rd=7, data 0x11) during WB of a load to rd=9 -> cycle shows rd=9 load data with `alu_stall=1`; next cycle rd=7/0x11 written with `alu_stall=0`.
- **x0 load and reset mid-operation:**
  - Load to rd=0 -> memory access occurs, `write_en_3` stays 0.
  - `rst_n` low during REQ -> `mem_req=0`, `busy_valid=0` next cycle, no writeback, `ld_ready=1`.
